// File: rtl/avg_pkg.sv
// Shared types and sizing helpers for the moving-average filter.
package avg_pkg;

   // Behaviour of the output stage before the window has filled.
   typedef enum logic {
      WARM_ZERO_FILL = 1'b0,   // average from the first sample, missing samples read as zero
      WARM_HOLD      = 1'b1    // no output until the window is full
   } warmup_e;

   // Running-sum width. It holds DEPTH full-scale samples without overflowing.
   function automatic int sum_width(input int width, input int log2_depth);
      return width + log2_depth;
   endfunction

endpackage

// File: rtl/avg_ring_buffer.sv
// Sample window storage. The read is combinational so the oldest sample is
// visible in the same cycle that it gets overwritten. Storage is not reset.
module avg_ring_buffer
   import avg_pkg::*;
#(
   parameter  int WIDTH      = 12,
   parameter  int LOG2_DEPTH = 3,
   localparam int DEPTH      = 2 ** LOG2_DEPTH,
   localparam int ADDR_W     = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Read-before-write: rdata shows the old word until the clock edge commits wdata.
   assign rdata = mem[addr];

   // Write port only. No reset on storage.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/moving_average_filter.sv
// Moving-average filter for distance-sensor readings. A sample is taken on each
// falling edge of trig. Two clocks after that edge, avg_out shows the mean of
// the last DEPTH samples and avg_valid pulses for one cycle.
module moving_average_filter
   import avg_pkg::*;
#(
   parameter int WIDTH      = 12,
   parameter int LOG2_DEPTH = 3,
   parameter int WARMUP     = 0,
   parameter int ROUND      = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             trig,
   input  logic [WIDTH-1:0] sample_in,
   input  logic             flush,
   output logic [WIDTH-1:0] avg_out,
   output logic             avg_valid,
   output logic             primed
);

   localparam int DEPTH = 2 ** LOG2_DEPTH;
   localparam int SUM_W = sum_width(WIDTH, LOG2_DEPTH);
   localparam int RND_W = SUM_W + 1;
   localparam int PTR_W = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
   localparam int CNT_W = LOG2_DEPTH + 1;
   // Half an LSB of the output. It is zero when DEPTH is 1 or when rounding is off.
   localparam int RND   = (ROUND != 0) ? (DEPTH / 2) : 0;
   localparam bit HOLD  = (WARMUP == int'(WARM_HOLD));

   logic             last_trig_reg;
   logic             trig_event;
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [SUM_W-1:0] sum_reg, sum_next;
   logic             pend_reg;
   logic [WIDTH-1:0] avg_out_reg;
   logic             avg_valid_reg;
   logic             primed_reg;
   logic [WIDTH-1:0] oldest;
   logic             window_full;
   logic             buf_we;
   logic [RND_W-1:0] rnd_sum;
   logic [WIDTH-1:0] avg_calc;
   logic             update_ok;

   assign trig_event  = ~trig & last_trig_reg;
   assign window_full = (count_reg == CNT_W'(DEPTH));
   // A sample taken in the same cycle as a flush is discarded.
   assign buf_we      = trig_event & ~flush & ~reset;

   avg_ring_buffer #(
      .WIDTH      (WIDTH),
      .LOG2_DEPTH (LOG2_DEPTH)
   ) u_ring (
      .clk   (clk),
      .we    (buf_we),
      .addr  (wr_ptr_reg),
      .wdata (sample_in),
      .rdata (oldest)
   );

   // Window bookkeeping on an event. The oldest sample leaves the sum only once the window is full.
   always_comb begin
      sum_next    = sum_reg;
      count_next  = count_reg;
      wr_ptr_next = wr_ptr_reg;
      if (trig_event) begin
         sum_next    = sum_reg + SUM_W'(sample_in) - (window_full ? SUM_W'(oldest) : SUM_W'(0));
         count_next  = window_full ? count_reg : count_reg + 1'b1;
         wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
   end

   // Output arithmetic. The extra adder bit absorbs the rounding term, and the
   // shifted result always fits in WIDTH bits.
   always_comb begin
      rnd_sum   = {1'b0, sum_reg} + RND_W'(RND);
      avg_calc  = WIDTH'(rnd_sum >> LOG2_DEPTH);
      update_ok = HOLD ? window_full : 1'b1;
   end

   // State registers: trig history, window state, and the output stage one edge after the event.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_trig_reg <= 1'b0;
         wr_ptr_reg    <= '0;
         count_reg     <= '0;
         sum_reg       <= '0;
         pend_reg      <= 1'b0;
         avg_out_reg   <= '0;
         avg_valid_reg <= 1'b0;
         primed_reg    <= 1'b0;
      end else begin
         last_trig_reg <= trig;
         if (flush) begin
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            sum_reg       <= '0;
            pend_reg      <= 1'b0;
            avg_out_reg   <= '0;
            avg_valid_reg <= 1'b0;
            primed_reg    <= 1'b0;
         end else begin
            wr_ptr_reg    <= wr_ptr_next;
            count_reg     <= count_next;
            sum_reg       <= sum_next;
            primed_reg    <= (count_next == CNT_W'(DEPTH));
            pend_reg      <= trig_event;
            avg_valid_reg <= 1'b0;
            if (pend_reg && update_ok) begin
               avg_out_reg   <= avg_calc;
               avg_valid_reg <= 1'b1;
            end
         end
      end
   end

   assign avg_out   = avg_out_reg;
   assign avg_valid = avg_valid_reg;
   assign primed    = primed_reg;

endmodule

// File: tb/tb_moving_average_filter.sv
// Directed bench for moving_average_filter. Three instances share one stimulus:
// A = zero-fill/truncate, B = hold-until-full/truncate, C = zero-fill/round.
module tb_moving_average_filter;

   logic        clk = 1'b0;
   logic        reset;
   logic        trig;
   logic        flush;
   logic [11:0] sample_in;
   logic [11:0] avg_a, avg_b, avg_c;
   logic        val_a, val_b, val_c;
   logic        pr_a, pr_b, pr_c;

   int passed = 0;
   int total  = 0;

   typedef struct {
      bit          rst;      // apply reset before this event
      int unsigned smp;
      int unsigned a_avg;
      bit          b_valid;
      int unsigned b_avg;
      int unsigned c_avg;
      bit          primed;
   } vec_t;

   vec_t vec[$];

   always #5 clk = ~clk;

   moving_average_filter #(.WIDTH(12), .LOG2_DEPTH(3), .WARMUP(0), .ROUND(0)) dut_a (
      .clk(clk), .reset(reset), .trig(trig), .sample_in(sample_in), .flush(flush),
      .avg_out(avg_a), .avg_valid(val_a), .primed(pr_a));

   moving_average_filter #(.WIDTH(12), .LOG2_DEPTH(3), .WARMUP(1), .ROUND(0)) dut_b (
      .clk(clk), .reset(reset), .trig(trig), .sample_in(sample_in), .flush(flush),
      .avg_out(avg_b), .avg_valid(val_b), .primed(pr_b));

   moving_average_filter #(.WIDTH(12), .LOG2_DEPTH(3), .WARMUP(0), .ROUND(1)) dut_c (
      .clk(clk), .reset(reset), .trig(trig), .sample_in(sample_in), .flush(flush),
      .avg_out(avg_c), .avg_valid(val_c), .primed(pr_c));

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act == exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      trig      = 1'b0;
      flush     = 1'b0;
      sample_in = '0;
      tick();
      tick();
      reset = 1'b0;
      chk("reset avg_out a/b/c", {avg_a, avg_b, avg_c}, 0);
      chk("reset avg_valid a/b/c", {val_a, val_b, val_c}, 0);
      chk("reset primed a/b/c", {pr_a, pr_b, pr_c}, 0);
   endtask

   function automatic void add(bit rst, int unsigned smp, int unsigned a, bit bv,
                               int unsigned b, int unsigned c, bit pr);
      vec.push_back('{rst, smp, a, bv, b, c, pr});
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t3_avg[8]  = '{1, 3, 6, 10, 15, 21, 28, 36};
      int unsigned f_a[9]     = '{511, 1023, 1535, 2047, 2559, 3071, 3583, 4095, 4095};
      int unsigned f_c[9]     = '{512, 1024, 1536, 2048, 2559, 3071, 3583, 4095, 4095};
      int          pulses;
      int unsigned got_avg;
      vec_t        v;

      // Eight samples of 800 fill the window; B stays silent until the 8th.
      for (int k = 1; k <= 8; k++)
         add(k == 1, 800, 100 * k, k == 8, (k == 8) ? 800 : 0, 100 * k, k == 8);
      // A zero pushes out exactly one 800, then the window drains to zero.
      add(0, 0, 700, 1, 700, 700, 1);
      for (int k = 1; k <= 8; k++)
         add(0, 0, (k < 7) ? 700 - 100 * k : 0, 1, (k < 7) ? 700 - 100 * k : 0,
             (k < 7) ? 700 - 100 * k : 0, 1);
      // Ramp 8..64: rounding changes nothing here, and B reports only when full.
      for (int k = 1; k <= 8; k++)
         add(k == 1, 8 * k, t3_avg[k-1], k == 8, (k == 8) ? 36 : 0, t3_avg[k-1], k == 8);
      // A single small sample: truncation gives 0, rounding gives 1.
      add(1, 4, 0, 0, 0, 1, 0);
      // Full-scale samples: the sum reaches its maximum and stays there on the 9th.
      for (int k = 1; k <= 9; k++)
         add(k == 1, 4095, f_a[k-1], k >= 8, (k >= 8) ? 4095 : 0, f_c[k-1], k >= 8);

      reset     = 1'b1;
      trig      = 1'b0;
      flush     = 1'b0;
      sample_in = '0;
      tick();

      foreach (vec[i]) begin
         v = vec[i];
         if (v.rst) do_reset();
         trig = 1'b1;
         tick();
         trig      = 1'b0;
         sample_in = 12'(v.smp);
         tick();                                        // event edge E
         chk($sformatf("row%0d valid before E+1", i), {val_a, val_b, val_c}, 0);
         tick();                                        // edge E+1
         chk($sformatf("row%0d avg_a", i), avg_a, v.a_avg);
         chk($sformatf("row%0d valid_a", i), val_a, 1);
         chk($sformatf("row%0d avg_b", i), avg_b, v.b_avg);
         chk($sformatf("row%0d valid_b", i), val_b, v.b_valid);
         chk($sformatf("row%0d avg_c", i), avg_c, v.c_avg);
         chk($sformatf("row%0d valid_c", i), val_c, 1);
         chk($sformatf("row%0d primed a/b/c", i), {pr_a, pr_b, pr_c}, {3{v.primed}});
         tick();
         chk($sformatf("row%0d valid width", i), {val_a, val_b, val_c}, 0);
      end

      // A flush in the same cycle as an event clears the window and discards the sample.
      trig = 1'b1;
      tick();
      trig      = 1'b0;
      flush     = 1'b1;
      sample_in = 12'd500;
      tick();
      flush = 1'b0;
      chk("flush avg_out a/b/c", {avg_a, avg_b, avg_c}, 0);
      chk("flush primed", {pr_a, pr_b, pr_c}, 0);
      chk("flush valid E", {val_a, val_b, val_c}, 0);
      tick();
      chk("flush valid E+1", {val_a, val_b, val_c}, 0);
      tick();
      trig = 1'b1;
      tick();
      trig      = 1'b0;
      sample_in = 12'd80;
      tick();
      tick();
      chk("post-flush avg_a", avg_a, 10);
      chk("post-flush valid_a", val_a, 1);
      chk("post-flush avg_c", avg_c, 10);
      chk("post-flush valid_b", val_b, 0);
      chk("post-flush avg_b", avg_b, 0);
      chk("post-flush primed", pr_a, 0);
      tick();

      // trig held high through reset gives exactly one event when it falls.
      reset     = 1'b1;
      trig      = 1'b1;
      sample_in = 12'd160;
      tick();
      tick();
      reset = 1'b0;
      tick();
      trig    = 1'b0;
      pulses  = 0;
      got_avg = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (val_a) begin
            pulses++;
            got_avg = avg_a;
         end
      end
      chk("trig-through-reset pulses", pulses, 1);
      chk("trig-through-reset avg_a", got_avg, 20);

      // Reset between E and E+1 leaves no stale pulse and clears the output.
      trig = 1'b1;
      tick();
      trig      = 1'b0;
      sample_in = 12'd800;
      tick();                                           // edge E
      reset = 1'b1;
      tick();                                           // edge E+1 under reset
      chk("mid reset valid", {val_a, val_b, val_c}, 0);
      chk("mid reset avg_a", avg_a, 0);
      reset  = 1'b0;
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (val_a | val_b | val_c) pulses++;
      end
      chk("mid reset stale pulses", pulses, 0);
      chk("mid reset avg_out a/c", {avg_a, avg_c}, 0);
      chk("mid reset primed", pr_a, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
